// File: rtl/alu_bank_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_bank_core
//  Description : Two-unit ALU bank (arithmetic + logic/shift) with a fixed
//                two-cycle IDLE -> EXEC -> DONE sequence and a busy/valid
//                handshake. Result and {N,Z,C,V} flags are held until the
//                next completion.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_bank_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic [5:0]            opcode,
    input  logic                  enable,
    input  logic                  alu_select,
    output logic [DATA_WIDTH-1:0] result,
    output logic [3:0]            flags,
    output logic                  valid,
    output logic                  busy
);

    localparam int c_SH_W = $clog2(DATA_WIDTH);
    localparam int c_MSB  = DATA_WIDTH - 1;
    localparam logic [c_SH_W:0]       c_WIDTH = (c_SH_W + 1)'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] c_ONE   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] c_ZERO  = '0;

    // Arithmetic unit sub-opcodes
    localparam logic [3:0] c_OP_ADD  = 4'h0;
    localparam logic [3:0] c_OP_SUB  = 4'h1;
    localparam logic [3:0] c_OP_INC  = 4'h2;
    localparam logic [3:0] c_OP_DEC  = 4'h3;
    localparam logic [3:0] c_OP_MUL  = 4'h4;
    localparam logic [3:0] c_OP_NEG  = 4'h5;
    localparam logic [3:0] c_OP_PASS = 4'h6;
    // Logic/shift unit sub-opcodes
    localparam logic [3:0] c_OP_AND  = 4'h0;
    localparam logic [3:0] c_OP_OR   = 4'h1;
    localparam logic [3:0] c_OP_XOR  = 4'h2;
    localparam logic [3:0] c_OP_NOT  = 4'h3;
    localparam logic [3:0] c_OP_NAND = 4'h4;
    localparam logic [3:0] c_OP_NOR  = 4'h5;
    localparam logic [3:0] c_OP_SHL  = 4'h6;
    localparam logic [3:0] c_OP_SHR  = 4'h7;
    localparam logic [3:0] c_OP_SAR  = 4'h8;
    localparam logic [3:0] c_OP_ROL  = 4'h9;
    localparam logic [3:0] c_OP_ROR  = 4'hA;
    localparam logic [3:0] c_OP_XNOR = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [5:0]            r_op;
    logic                  r_sel;
    logic [DATA_WIDTH-1:0] r_result;
    logic [3:0]            r_flags;
    logic                  r_valid;
    logic                  r_busy;

    logic [DATA_WIDTH-1:0]   w_x;
    logic [DATA_WIDTH-1:0]   w_y;
    logic [DATA_WIDTH:0]     w_sum;
    logic [DATA_WIDTH:0]     w_diff;
    logic                    w_add_v;
    logic                    w_sub_v;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic                    w_mul_hi;
    logic [c_SH_W-1:0]       w_sh;
    logic                    w_sh_nz;
    logic [c_SH_W:0]         w_rsh;
    logic [DATA_WIDTH:0]     w_shl;
    logic [DATA_WIDTH:0]     w_shr;
    logic [DATA_WIDTH:0]     w_sar;
    logic [DATA_WIDTH-1:0]   w_rol;
    logic [DATA_WIDTH-1:0]   w_ror;
    logic [DATA_WIDTH-1:0]   w_res;
    logic                    w_c;
    logic                    w_v;
    logic                    w_undef;
    logic [3:0]              w_flags;

    // Shared adder/subtractor operand steering: INC/DEC use a constant one,
    // NEG is computed as 0 - a so borrow and overflow fall out of the subtractor.
    always_comb begin
        w_x = r_a;
        w_y = r_b;
        if (r_op[3:0] == c_OP_INC || r_op[3:0] == c_OP_DEC) begin
            w_y = c_ONE;
        end else if (r_op[3:0] == c_OP_NEG) begin
            w_x = c_ZERO;
            w_y = r_a;
        end
    end

    // Datapath primitives; the extra bit on shifts captures the last bit out.
    always_comb begin
        w_sum    = {1'b0, w_x} + {1'b0, w_y};
        w_diff   = {1'b0, w_x} - {1'b0, w_y};
        w_add_v  = (w_x[c_MSB] == w_y[c_MSB]) && (w_sum[c_MSB] != w_x[c_MSB]);
        w_sub_v  = (w_x[c_MSB] != w_y[c_MSB]) && (w_diff[c_MSB] != w_x[c_MSB]);
        w_prod   = {{DATA_WIDTH{1'b0}}, r_a} * {{DATA_WIDTH{1'b0}}, r_b};
        w_mul_hi = |w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
        w_sh     = r_b[c_SH_W-1:0];
        w_sh_nz  = |w_sh;
        w_rsh    = c_WIDTH - {1'b0, w_sh};
        w_shl    = {1'b0, r_a} << w_sh;
        w_shr    = {r_a, 1'b0} >> w_sh;
        w_sar    = $signed({r_a, 1'b0}) >>> w_sh;
        // A shift by the full width yields zero, so sh=0 degenerates cleanly.
        w_rol    = (r_a << w_sh) | (r_a >> w_rsh);
        w_ror    = (r_a >> w_sh) | (r_a << w_rsh);
    end

    // Unit selection and per-operation result/carry/overflow.
    always_comb begin
        w_res   = c_ZERO;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_undef = 1'b0;
        if (r_op[5:4] == 2'b00 && !r_sel) begin
            case (r_op[3:0])
                c_OP_ADD, c_OP_INC: begin
                    w_res = w_sum[DATA_WIDTH-1:0];
                    w_c   = w_sum[DATA_WIDTH];
                    w_v   = w_add_v;
                end
                c_OP_SUB, c_OP_DEC, c_OP_NEG: begin
                    w_res = w_diff[DATA_WIDTH-1:0];
                    w_c   = w_diff[DATA_WIDTH];
                    w_v   = w_sub_v;
                end
                c_OP_MUL: begin
                    w_res = w_prod[DATA_WIDTH-1:0];
                    w_c   = w_mul_hi;
                    w_v   = w_mul_hi;
                end
                c_OP_PASS: w_res = r_a;
                default:   w_undef = 1'b1;
            endcase
        end else if (r_op[5:4] == 2'b01 && r_sel) begin
            case (r_op[3:0])
                c_OP_AND:  w_res = r_a & r_b;
                c_OP_OR:   w_res = r_a | r_b;
                c_OP_XOR:  w_res = r_a ^ r_b;
                c_OP_NOT:  w_res = ~r_a;
                c_OP_NAND: w_res = ~(r_a & r_b);
                c_OP_NOR:  w_res = ~(r_a | r_b);
                c_OP_XNOR: w_res = ~(r_a ^ r_b);
                c_OP_SHL: begin
                    w_res = w_shl[DATA_WIDTH-1:0];
                    w_c   = w_shl[DATA_WIDTH];
                end
                c_OP_SHR: begin
                    w_res = w_shr[DATA_WIDTH:1];
                    w_c   = w_shr[0];
                end
                c_OP_SAR: begin
                    w_res = w_sar[DATA_WIDTH:1];
                    w_c   = w_sar[0];
                end
                c_OP_ROL: begin
                    w_res = w_rol;
                    w_c   = w_sh_nz & w_rol[0];
                end
                c_OP_ROR: begin
                    w_res = w_ror;
                    w_c   = w_sh_nz & w_ror[c_MSB];
                end
                default: w_undef = 1'b1;
            endcase
        end else begin
            w_undef = 1'b1;
        end
        w_flags = w_undef ? 4'b0100
                          : {w_res[c_MSB], (w_res == c_ZERO), w_c, w_v};
    end

    // Control FSM: capture in IDLE, one compute cycle, publish in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_sel    <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_a     <= operand_a;
                        r_b     <= operand_b;
                        r_op    <= opcode;
                        r_sel   <= alu_select;
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_result <= w_res;
                    r_flags  <= w_flags;
                    r_valid  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign result = r_result;
    assign flags  = r_flags;
    assign valid  = r_valid;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_bank_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_bank_core
//  Description : Directed self-checking bench for alu_bank_core.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_bank_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [5:0]  opcode;
    logic        enable;
    logic        alu_select;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        valid;
    logic        busy;

    int n_pass;
    int n_checks;

    alu_bank_core #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .opcode     (opcode),
        .enable     (enable),
        .alu_select (alu_select),
        .result     (result),
        .flags      (flags),
        .valid      (valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic        sel;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;

    // Start one operation and wait (bounded) for valid. Returns at #1 after
    // the valid edge with lat = edges from the enable edge to valid.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] op, input logic sel, output int lat);
        @(negedge clk);
        operand_a  = a;
        operand_b  = b;
        opcode     = op;
        alu_select = sel;
        enable     = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        lat = 0;
        while (!valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        n_checks++; if (result !== 32'h0) $display("FAIL reset_result got %h want %h", result, 32'h0); else n_pass++;
        n_checks++; if (flags !== 4'h0)   $display("FAIL reset_flags got %b want %b", flags, 4'h0); else n_pass++;
        n_checks++; if (valid !== 1'b0)   $display("FAIL reset_valid got %b want 0", valid); else n_pass++;
        n_checks++; if (busy !== 1'b0)    $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_add_timing();
        int lat;
        @(negedge clk);
        operand_a = 32'h12345678; operand_b = 32'h87654321;
        opcode = 6'b000000; alu_select = 1'b0; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        n_checks++; if (busy !== 1'b1 || valid !== 1'b0) $display("FAIL add_edgeN busy/valid got %b%b want 10", busy, valid); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1 || valid !== 1'b0) $display("FAIL add_edgeN1 busy/valid got %b%b want 10", busy, valid); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (valid !== 1'b1 || busy !== 1'b0) $display("FAIL add_edgeN2 valid/busy got %b%b want 10", valid, busy); else n_pass++;
        n_checks++; if (result !== 32'h99999999) $display("FAIL add_result got %h want %h", result, 32'h99999999); else n_pass++;
        n_checks++; if (flags !== 4'b1000) $display("FAIL add_flags got %b want %b", flags, 4'b1000); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (valid !== 1'b0) $display("FAIL add_valid_pulse got %b want 0", valid); else n_pass++;
        n_checks++; if (result !== 32'h99999999) $display("FAIL add_hold got %h want %h", result, 32'h99999999); else n_pass++;
        lat = 0;
    endtask

    task automatic test_ops();
        vec_t v[14];
        int lat;
        v[0]  = '{32'hAAAAAAAA, 32'h55555555, 6'b010010, 1'b1, 32'hFFFFFFFF, 4'b1000}; // XOR
        v[1]  = '{32'hDEADBEEF, 32'h00000010, 6'b000100, 1'b0, 32'hEADBEEF0, 4'b1011}; // MUL
        v[2]  = '{32'h00000001, 32'h00000008, 6'b010110, 1'b1, 32'h00000100, 4'b0000}; // SHL
        v[3]  = '{32'h00000005, 32'h00000005, 6'b000001, 1'b0, 32'h00000000, 4'b0100}; // SUB
        v[4]  = '{32'h7FFFFFFF, 32'h00000001, 6'b000000, 1'b0, 32'h80000000, 4'b1001}; // ADD ovf
        v[5]  = '{32'h00000000, 32'h00000001, 6'b000001, 1'b0, 32'hFFFFFFFF, 4'b1010}; // SUB borrow
        v[6]  = '{32'h80000000, 32'h00000000, 6'b000101, 1'b0, 32'h80000000, 4'b1011}; // NEG min
        v[7]  = '{32'h00000003, 32'h00000004, 6'b000100, 1'b0, 32'h0000000C, 4'b0000}; // MUL small
        v[8]  = '{32'h80000000, 32'h00000004, 6'b011000, 1'b1, 32'hF8000000, 4'b1000}; // SAR
        v[9]  = '{32'h00000001, 32'h00000001, 6'b011010, 1'b1, 32'h80000000, 4'b1010}; // ROR
        v[10] = '{32'h80000000, 32'h00000001, 6'b011001, 1'b1, 32'h00000001, 4'b0010}; // ROL
        v[11] = '{32'h00000003, 32'h00000001, 6'b010111, 1'b1, 32'h00000001, 4'b0010}; // SHR
        v[12] = '{32'h12345678, 32'h12345678, 6'b011011, 1'b1, 32'hFFFFFFFF, 4'b1000}; // XNOR
        v[13] = '{32'hC0000001, 32'h00000000, 6'b010110, 1'b1, 32'hC0000001, 4'b1000}; // SHL sh=0
        for (int i = 0; i < 14; i++) begin
            issue(v[i].a, v[i].b, v[i].op, v[i].sel, lat);
            n_checks++; if (lat !== 2) $display("FAIL op%0d_latency got %0d want 2", i, lat); else n_pass++;
            n_checks++; if (result !== v[i].res) $display("FAIL op%0d_result got %h want %h", i, result, v[i].res); else n_pass++;
            n_checks++; if (flags !== v[i].fl) $display("FAIL op%0d_flags got %b want %b", i, flags, v[i].fl); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(32'hFFFFFFFF, 32'h0, 6'b000010, 1'b0, lat); // INC
        n_checks++; if (result !== 32'h0 || flags !== 4'b0110) $display("FAIL b2b_first got %h/%b want 00000000/0110", result, flags); else n_pass++;
        // valid is high now; request the next op in this same cycle
        operand_a = 32'h0; operand_b = 32'h0; opcode = 6'b000011; alu_select = 1'b0;
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL b2b_accept busy got %b want 1", busy); else n_pass++;
        lat = 0;
        while (!valid && lat < 8) begin
            @(posedge clk); #1; lat++;
        end
        n_checks++; if (lat !== 2) $display("FAIL b2b_latency got %0d want 2", lat); else n_pass++;
        n_checks++; if (result !== 32'hFFFFFFFF || flags !== 4'b1010) $display("FAIL b2b_second got %h/%b want FFFFFFFF/1010", result, flags); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int extra;
        @(negedge clk);
        operand_a = 32'h1; operand_b = 32'h2; opcode = 6'b000000; alu_select = 1'b0;
        enable = 1'b1;
        @(posedge clk); #1;
        // hold enable with a different op through the busy window
        operand_a = 32'h0; opcode = 6'b010011; alu_select = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (valid !== 1'b0) $display("FAIL ign_early_valid got %b want 0", valid); else n_pass++;
        @(posedge clk); #1;
        enable = 1'b0;
        n_checks++; if (valid !== 1'b1) $display("FAIL ign_valid got %b want 1", valid); else n_pass++;
        n_checks++; if (result !== 32'h3 || flags !== 4'b0000) $display("FAIL ign_result got %h/%b want 00000003/0000", result, flags); else n_pass++;
        extra = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (valid) extra++;
        end
        n_checks++; if (extra !== 0) $display("FAIL ign_extra_valid got %0d want 0", extra); else n_pass++;
        n_checks++; if (result !== 32'h3) $display("FAIL ign_hold got %h want %h", result, 32'h3); else n_pass++;
    endtask

    task automatic test_reset_mid_exec();
        int seen;
        @(negedge clk);
        operand_a = 32'h10; operand_b = 32'h20; opcode = 6'b000000; alu_select = 1'b0;
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++; if (valid !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid valid/busy got %b%b want 00", valid, busy); else n_pass++;
        n_checks++; if (result !== 32'h0 || flags !== 4'h0) $display("FAIL rst_mid_out got %h/%b want 00000000/0000", result, flags); else n_pass++;
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (valid) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL rst_mid_late_valid got %0d want 0", seen); else n_pass++;
    endtask

    task automatic test_undefined();
        int lat;
        issue(32'h11111111, 32'h1, 6'b100000, 1'b0, lat);
        n_checks++; if (lat !== 2) $display("FAIL undef_latency got %0d want 2", lat); else n_pass++;
        n_checks++; if (result !== 32'h0 || flags !== 4'b0100) $display("FAIL undef_op got %h/%b want 00000000/0100", result, flags); else n_pass++;
        issue(32'h7, 32'h1, 6'b000000, 1'b0, lat);
        n_checks++; if (result !== 32'h8) $display("FAIL undef_prep got %h want %h", result, 32'h8); else n_pass++;
        issue(32'hAAAAAAAA, 32'h55555555, 6'b010010, 1'b0, lat);
        n_checks++; if (lat !== 2) $display("FAIL mismatch_latency got %0d want 2", lat); else n_pass++;
        n_checks++; if (result !== 32'h0 || flags !== 4'b0100) $display("FAIL mismatch_op got %h/%b want 00000000/0100", result, flags); else n_pass++;
        issue(32'h5, 32'h0, 6'b000111, 1'b0, lat);
        n_checks++; if (result !== 32'h0 || flags !== 4'b0100) $display("FAIL undef_arith_sub got %h/%b want 00000000/0100", result, flags); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_checks = 0;
        rst_n = 1'b0;
        enable = 1'b0;
        operand_a = '0;
        operand_b = '0;
        opcode = '0;
        alu_select = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_add_timing();
        test_ops();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_exec();
        test_undefined();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_bank_core.md
Name: alu_bank_core

Overview:
- Two-unit parallel ALU bank: an arithmetic unit and a logic/shift unit, selected per operation.
- Registered, fixed-latency operation with a busy/valid handshake.
- Sits at the head of the datapath. Its held result feeds the downstream CRC32 and Hamming stages.

Parameters:
DATA_WIDTH, 32, operand/result width (must be >= 8; shift amounts use operand_b[log2(DATA_WIDTH)-1:0])

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
operand_a  input  DATA_WIDTH  first operand
operand_b  input  DATA_WIDTH  second operand / shift amount
opcode  input  6  operation code, see map
enable  input  1  start request, sampled on rising edge
alu_select  input  1  0 = arithmetic unit, 1 = logic/shift unit
result  output  DATA_WIDTH  registered result, held until next completion
flags  output  4  {N,Z,C,V}, registered alongside result
valid  output  1  one-cycle completion pulse
busy  output  1  high while an operation is in flight

Behaviour:
- Reset: rst_n sampled low at a clk edge forces result=0, flags=0, valid=0, busy=0 and the FSM to IDLE. An in-flight operation is discarded.
- FSM states:
  - IDLE: enable=1 at edge N captures operand_a, operand_b, opcode and alu_select, then moves to EXEC; busy=1 after edge N.
  - EXEC: computes; at edge N+1 moves to DONE.
  - DONE: at edge N+2 result/flags are updated, valid=1 for exactly one cycle, busy=0, then back to IDLE.
- Latency: 2 cycles from the enable edge to the valid edge.
- enable while busy=1 is ignored and not queued. enable asserted in the cycle valid is high is accepted (back-to-back).
- result and flags hold their last values until the next completion.
- Legal encodings: opcode[5:4]=00 requires alu_select=0; opcode[5:4]=01 requires alu_select=1. Any other combination (including opcode[5]=1 or a select mismatch) is undefined: result=0, flags=0100, valid still pulses.
- Arithmetic unit (00xxxx):
  - 0000 ADD a+b
  - 0001 SUB a-b
  - 0010 INC a+1
  - 0011 DEC a-1
  - 0100 MUL low DATA_WIDTH bits of a*b (unsigned)
  - 0101 NEG 0-a
  - 0110 PASS a
  - others undefined
- Logic unit (01xxxx):
  - 0000 AND
  - 0001 OR
  - 0010 XOR
  - 0011 NOT a
  - 0100 NAND
  - 0101 NOR
  - 0110 SHL a<<sh
  - 0111 SHR logical
  - 1000 SAR arithmetic
  - 1001 ROL
  - 1010 ROR
  - 1011 XNOR
  - others undefined
  - sh = operand_b[4:0] for DATA_WIDTH=32.
- Flags:
  - N = result MSB; Z = (result==0).
  - ADD/INC: C = carry-out; V = signed overflow.
  - SUB/DEC/NEG: C = borrow (1 when unsigned a<b); V = signed overflow.
  - MUL: C = V = 1 when the upper half of the full 2*DATA_WIDTH product is nonzero.
  - Shifts/rotates: C = last bit shifted out (0 when sh=0); V = 0.
  - Logic ops and PASS: C = V = 0.

Test Plan:
- ADD a=12345678 b=87654321 opcode=000000 sel=0 -> result 99999999, flags 1000. Valid exactly 2 cycles after the enable edge; busy high for those 2 cycles.
- XOR a=AAAAAAAA b=55555555 opcode=010010 sel=1 -> result FFFFFFFF, flags 1000.
- MUL a=DEADBEEF b=00000010 opcode=000100 sel=0 -> result EADBEEF0, flags 1011.
- SHL a=00000001 b=00000008 opcode=010110 sel=1 -> result 00000100, flags 0000. SUB a=5 b=5 opcode=000001 -> result 0, flags 0100.
- Handshake: enable pulsed again while busy -> ignored, a single valid pulse, result unchanged afterwards. rst_n low mid-EXEC -> no valid, outputs 0.
- Undefined opcode 100000 or sel mismatch (opcode 010010, sel=0) -> result 0, flags 0100, valid pulses after 2 cycles.
